// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, flag bit positions, format widths
// and the unpacked-operand record used by the add/sub scheduler.
package fpu_pkg;

  localparam int FLEN  = 32;
  localparam int EXP_W = 8;
  localparam int SIG_W = 24;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100,
    RM_DYN = 3'b111
  } rm_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
    logic             quiet;
  } fp_unpacked_t;

  // Reserved encodings (101/110, or a dynamic frm holding them) fall back to RNE.
  function automatic rm_e resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
    logic [2:0] sel;
    sel = (rm == RM_DYN) ? frm : rm;
    case (sel)
      3'b001:  return RM_RTZ;
      3'b010:  return RM_RDN;
      3'b011:  return RM_RUP;
      3'b100:  return RM_RMM;
      default: return RM_RNE;
    endcase
  endfunction

endpackage

// File: rtl/fpu_add_sub.sv
// Combinational binary32 add/subtract with IEEE rounding and exception flags.
module fpu_add_sub
  import fpu_pkg::*;
(
  input  fp_unpacked_t    a_i,
  input  fp_unpacked_t    b_i,
  input  logic            sub_i,
  input  rm_e             rm_i,
  output logic [FLEN-1:0] res_o,
  output logic [4:0]      flags_o
);

  logic        sb_s, eff_sub_s, swap_s, sign_big_s, rsign_s, signaling_s;
  logic [9:0]  ea_s, eb_s, e_big_s, diff_s, tmp_s, e_n_s, e_r_s;
  logic [23:0] sig_big_s, sig_sml_s;
  logic [4:0]  sh_s, msb_s, lz_s, shl_s;
  logic [26:0] al_s, lost_s, m_s;
  logic [27:0] sum_s;
  logic [24:0] mant_s;
  logic [7:0]  exp_f_s;
  logic        g_s, rs_s, nx_s, inc_s, of_s, ovf_inf_s;

  // Align, add, normalise, round, then override with special-operand results.
  always_comb begin
    res_o       = 32'h0000_0000;
    flags_o     = 5'b00000;
    sb_s        = b_i.sign ^ sub_i;
    eff_sub_s   = a_i.sign ^ sb_s;
    signaling_s = (a_i.is_nan & ~a_i.quiet) | (b_i.is_nan & ~b_i.quiet);
    ea_s        = (a_i.exp == 8'd0) ? 10'd1 : {2'b00, a_i.exp};
    eb_s        = (b_i.exp == 8'd0) ? 10'd1 : {2'b00, b_i.exp};
    swap_s      = {eb_s, b_i.sig} > {ea_s, a_i.sig};
    e_big_s     = swap_s ? eb_s : ea_s;
    sig_big_s   = swap_s ? b_i.sig : a_i.sig;
    sig_sml_s   = swap_s ? a_i.sig : b_i.sig;
    sign_big_s  = swap_s ? sb_s : a_i.sign;
    diff_s      = e_big_s - (swap_s ? ea_s : eb_s);
    sh_s        = (diff_s > 10'd27) ? 5'd27 : diff_s[4:0];
    al_s        = {sig_sml_s, 3'b000} >> sh_s;
    lost_s      = {sig_sml_s, 3'b000} & ((27'd1 << sh_s) - 27'd1);
    al_s[0]     = al_s[0] | (|lost_s);
    sum_s       = eff_sub_s ? ({1'b0, sig_big_s, 3'b000} - {1'b0, al_s})
                            : ({1'b0, sig_big_s, 3'b000} + {1'b0, al_s});
    msb_s = 5'd0;
    for (int i = 0; i < 27; i++) begin
      msb_s = sum_s[i] ? 5'(i) : msb_s;
    end
    lz_s  = 5'd26 - msb_s;
    tmp_s = e_big_s - 10'd1;
    // Left shift stops at exponent 1 so tiny results come out subnormal.
    if (sum_s[27]) begin
      shl_s = 5'd0;
      m_s   = {sum_s[27:2], sum_s[1] | sum_s[0]};
      e_n_s = e_big_s + 10'd1;
    end else begin
      shl_s = ({5'd0, lz_s} < tmp_s) ? lz_s : tmp_s[4:0];
      m_s   = sum_s[26:0] << shl_s;
      e_n_s = e_big_s - {5'd0, shl_s};
    end
    if (sum_s == 28'd0) begin
      rsign_s = (a_i.is_zero & b_i.is_zero & ~eff_sub_s) ? a_i.sign : (rm_i == RM_RDN);
    end else begin
      rsign_s = sign_big_s;
    end
    g_s  = m_s[2];
    rs_s = m_s[1] | m_s[0];
    nx_s = g_s | rs_s;
    case (rm_i)
      RM_RTZ:  begin inc_s = 1'b0;             ovf_inf_s = 1'b0;     end
      RM_RDN:  begin inc_s = nx_s & rsign_s;   ovf_inf_s = rsign_s;  end
      RM_RUP:  begin inc_s = nx_s & ~rsign_s;  ovf_inf_s = ~rsign_s; end
      RM_RMM:  begin inc_s = g_s;              ovf_inf_s = 1'b1;     end
      default: begin inc_s = g_s & (rs_s | m_s[3]); ovf_inf_s = 1'b1; end
    endcase
    mant_s = {1'b0, m_s[26:3]} + {24'd0, inc_s};
    if (mant_s[24]) begin
      mant_s = mant_s >> 1;
      e_r_s  = e_n_s + 10'd1;
    end else begin
      e_r_s  = e_n_s;
    end
    exp_f_s = mant_s[23] ? e_r_s[7:0] : 8'd0;
    of_s    = (e_r_s >= 10'd255);

    if (a_i.is_nan | b_i.is_nan) begin
      res_o            = 32'h7FC0_0000;
      flags_o[FLAG_NV] = signaling_s;
    end else if (a_i.is_inf & b_i.is_inf & eff_sub_s) begin
      res_o            = 32'h7FC0_0000;
      flags_o[FLAG_NV] = 1'b1;
    end else if (a_i.is_inf) begin
      res_o = {a_i.sign, 8'hFF, 23'd0};
    end else if (b_i.is_inf) begin
      res_o = {sb_s, 8'hFF, 23'd0};
    end else if (of_s) begin
      res_o            = ovf_inf_s ? {rsign_s, 8'hFF, 23'd0} : {rsign_s, 8'hFE, 23'h7FFFFF};
      flags_o[FLAG_OF] = 1'b1;
      flags_o[FLAG_NX] = 1'b1;
    end else begin
      res_o            = {rsign_s, exp_f_s, mant_s[22:0]};
      flags_o[FLAG_NX] = nx_s;
      flags_o[FLAG_UF] = nx_s & (exp_f_s == 8'd0);
    end
  end

endmodule

// File: rtl/fpu_addsub_unpack.sv
// Splits one raw binary32 operand into sign/exponent/significand and class bits.
module fpu_addsub_unpack
  import fpu_pkg::*;
(
  input  logic [FLEN-1:0] x_i,
  output fp_unpacked_t    u_o
);

  logic [EXP_W-1:0] exp_s;
  logic [22:0]      frac_s;

  assign exp_s  = x_i[30:23];
  assign frac_s = x_i[22:0];

  assign u_o = '{
    sign:    x_i[31],
    exp:     exp_s,
    sig:     {|exp_s, frac_s},
    is_zero: (exp_s == 8'h00) && (frac_s == 23'd0),
    is_inf:  (exp_s == 8'hFF) && (frac_s == 23'd0),
    is_nan:  (exp_s == 8'hFF) && (frac_s != 23'd0),
    quiet:   x_i[22]
  };

endmodule

// File: rtl/fpu_addsub_sched.sv
// Two-port round-robin scheduler feeding one shared add/sub datapath through
// a two-stage valid/ready pipeline, with flush and sticky fflags.
module fpu_addsub_sched
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [2*FLEN-1:0]    req_a_i,
  input  logic [2*FLEN-1:0]    req_b_i,
  input  logic [1:0]           req_sub_i,
  input  logic [5:0]           req_rm_i,
  input  logic [2*TAG_W-1:0]   req_tag_i,
  input  logic [2:0]           frm_i,
  input  logic                 flush_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [FLEN-1:0]      res_data_o,
  output logic [4:0]           res_flags_o,
  output logic                 res_port_o,
  output logic [TAG_W-1:0]     res_tag_o,
  output logic [4:0]           fflags_o,
  input  logic                 fflags_clr_i
);

  logic             s2_adv_s, s1_adv_s, gport_s, xfer_s, hs_s;
  logic [1:0]       grant_s;
  logic [FLEN-1:0]  a_raw_s, b_raw_s, dp_res_s;
  logic [4:0]       dp_flags_s;
  fp_unpacked_t     ua_s, ub_s;

  logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d, rr_q, rr_d;
  fp_unpacked_t     s1_a_q, s1_b_q;
  logic             s1_sub_q, s1_port_q;
  rm_e              s1_rm_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [FLEN-1:0]  res_data_q;
  logic [4:0]       res_flags_q, fflags_q, fflags_d;
  logic             res_port_q;
  logic [TAG_W-1:0] res_tag_q;

  assign s2_adv_s    = ~s2_v_q | res_ready_i;
  assign s1_adv_s    = ~s1_v_q | s2_adv_s;
  // rr_q = 1 hands the tie to port1; no grant at all while S1 is stuck.
  assign grant_s[0]  = s1_adv_s & req_valid_i[0] & (~req_valid_i[1] | ~rr_q);
  assign grant_s[1]  = s1_adv_s & req_valid_i[1] & (~req_valid_i[0] | rr_q);
  assign req_ready_o = grant_s & {2{~flush_i}};
  assign xfer_s      = |(req_valid_i & req_ready_o);
  assign gport_s     = grant_s[1];
  assign a_raw_s     = gport_s ? req_a_i[2*FLEN-1:FLEN] : req_a_i[FLEN-1:0];
  assign b_raw_s     = gport_s ? req_b_i[2*FLEN-1:FLEN] : req_b_i[FLEN-1:0];
  assign hs_s        = s2_v_q & res_ready_i & ~flush_i;

  fpu_addsub_unpack u_unpack_a (.x_i(a_raw_s), .u_o(ua_s));
  fpu_addsub_unpack u_unpack_b (.x_i(b_raw_s), .u_o(ub_s));

  fpu_add_sub u_add_sub (
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .sub_i   (s1_sub_q),
    .rm_i    (s1_rm_q),
    .res_o   (dp_res_s),
    .flags_o (dp_flags_s)
  );

  // Next-state for stage valids, arbitration pointer and sticky flags.
  always_comb begin
    s1_v_d = flush_i ? 1'b0 : (s1_adv_s ? xfer_s : s1_v_q);
    s2_v_d = flush_i ? 1'b0 : (s2_adv_s ? s1_v_q : s2_v_q);
    rr_d   = xfer_s ? ~gport_s : rr_q;
    if (fflags_clr_i) begin
      fflags_d = hs_s ? res_flags_q : 5'b00000;
    end else begin
      fflags_d = fflags_q | (hs_s ? res_flags_q : 5'b00000);
    end
  end

  // Pipeline, pointer and flag registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      rr_q        <= 1'b0;
      fflags_q    <= 5'b00000;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_sub_q    <= 1'b0;
      s1_rm_q     <= RM_RNE;
      s1_port_q   <= 1'b0;
      s1_tag_q    <= '0;
      res_data_q  <= 32'h0000_0000;
      res_flags_q <= 5'b00000;
      res_port_q  <= 1'b0;
      res_tag_q   <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s2_v_q   <= s2_v_d;
      rr_q     <= rr_d;
      fflags_q <= fflags_d;
      if (xfer_s) begin
        s1_a_q    <= ua_s;
        s1_b_q    <= ub_s;
        s1_sub_q  <= req_sub_i[gport_s];
        s1_rm_q   <= resolve_rm(gport_s ? req_rm_i[5:3] : req_rm_i[2:0], frm_i);
        s1_port_q <= gport_s;
        s1_tag_q  <= gport_s ? req_tag_i[2*TAG_W-1:TAG_W] : req_tag_i[TAG_W-1:0];
      end
      if (s2_adv_s & s1_v_q & ~flush_i) begin
        res_data_q  <= dp_res_s;
        res_flags_q <= dp_flags_s;
        res_port_q  <= s1_port_q;
        res_tag_q   <= s1_tag_q;
      end
    end
  end

  assign res_valid_o = s2_v_q;
  assign res_data_o  = res_data_q;
  assign res_flags_o = res_flags_q;
  assign res_port_o  = res_port_q;
  assign res_tag_o   = res_tag_q;
  assign fflags_o    = fflags_q;

endmodule
